// File: rtl/credit_link_pkg.sv
// Shared types and sizing helpers for the credit-based push link blocks.
package credit_link_pkg;

    typedef enum logic [1:0] {
        IN_RESET = 2'd0,
        WAIT_RX  = 2'd1,
        ACTIVE   = 2'd2
    } link_state_t;

    // Credit capacity used by both the sender and receiver sides of the link.
    localparam int DEFAULT_MAX_CREDITS = 4;

    // Width of a counter that must hold 0..max_credits inclusive.
    function automatic int cnt_width(input int max_credits);
        return $clog2(max_credits + 1);
    endfunction

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/credit_link_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter
    import credit_link_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    // Walk requesters starting at ptr and keep only the first hit.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
            if (enable && !found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/credit_link_arbiter.sv
// Sender-side scheduler for a credit-based push link: round-robin over
// requesters, one beat per credit, plus the link reset handshake.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IN_RESET | first cycle out of reset; tells the receiver we are initialising
//   WAIT_RX  | receiver still in reset; credits held at 0 and returns ignored
//   ACTIVE   | normal traffic; grants consume credits, returns replenish them
module credit_link_arbiter
    import credit_link_pkg::*;
#(
    parameter int  NUM_REQ     = 4,
    parameter int  DATA_W      = 8,
    parameter int  MAX_CREDITS = DEFAULT_MAX_CREDITS,
    localparam int CNT_W       = cnt_width(MAX_CREDITS),
    localparam int IDX_W       = idx_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      push_valid,
    output logic [DATA_W-1:0]         push_data,
    input  logic                      push_credit,
    output logic                      push_credit_stall,
    output logic                      push_sender_in_reset,
    input  logic                      push_receiver_in_reset,
    output logic [CNT_W-1:0]          credit_count,
    output logic                      credit_available,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      credit_overflow
);

    link_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  gid_q, gid_d;
    logic              pv_q, pv_d;
    logic [DATA_W-1:0] pd_q, pd_d;
    logic              ovf_q, ovf_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               arb_en;
    logic               at_max;

    // Grants use only the registered count, so a credit returned at zero
    // becomes usable one cycle later.
    assign at_max    = (cnt_q == CNT_W'(MAX_CREDITS));
    assign arb_en    = (state_q == ACTIVE) && (cnt_q != '0);
    assign grant_any = |grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Next-state, credit arithmetic and beat capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        pv_d    = 1'b0;
        pd_d    = pd_q;
        ovf_d   = ovf_q;

        if (grant_any) begin
            pv_d  = 1'b1;
            pd_d  = req_data[int'(grant_idx)*DATA_W +: DATA_W];
            ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
            gid_d = grant_idx;
        end

        case (state_q)
            IN_RESET: state_d = push_receiver_in_reset ? WAIT_RX : ACTIVE;
            WAIT_RX: begin
                cnt_d = '0;
                if (!push_receiver_in_reset) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (push_receiver_in_reset) begin
                    // A beat granted this cycle still goes out; credits are void.
                    state_d = WAIT_RX;
                    cnt_d   = '0;
                end else if (push_credit && !grant_any) begin
                    if (at_max) ovf_d = 1'b1;
                    else        cnt_d = cnt_q + CNT_W'(1);
                end else if (!push_credit && grant_any) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IN_RESET;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IN_RESET;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
            pv_q    <= 1'b0;
            pd_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            pv_q    <= pv_d;
            pd_q    <= pd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign req_ready            = grant;
    assign push_valid           = pv_q;
    assign push_data            = pd_q;
    assign push_credit_stall    = (state_q != ACTIVE) || at_max;
    assign push_sender_in_reset = (state_q == IN_RESET);
    assign credit_count         = cnt_q;
    assign credit_available     = arb_en;
    assign grant_id             = gid_q;
    assign credit_overflow      = ovf_q;

endmodule

// File: doc/credit_link_arbiter.md
Name: credit_link_arbiter

Overview:
- Sender-side scheduler for a credit-based push link whose far end is a credit receiver.
- Shares one link between NUM_REQ requesters using round-robin arbitration, one beat per grant.
- Tracks returned credits and never issues a beat without a credit.
- Sequences the link reset handshake: sender-in-reset / receiver-in-reset.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_W, 8, payload width per beat
MAX_CREDITS, 4, credit counter capacity (>=1); CNT_W = $clog2(MAX_CREDITS+1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester beat valid
req_data  in  NUM_REQ*DATA_W  per-requester payload, requester i at [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-hot grant; beat i accepted when req_valid[i] & req_ready[i]
push_valid  out  1  registered link beat valid
push_data  out  DATA_W  registered link payload
push_credit  in  1  one credit returned by receiver this cycle
push_credit_stall  out  1  asks receiver to hold credit returns
push_sender_in_reset  out  1  this block is in reset or initialising
push_receiver_in_reset  in  1  receiver is in reset
credit_count  out  CNT_W  current credits held
credit_available  out  1  credit_count != 0 and state ACTIVE
grant_id  out  $clog2(NUM_REQ)  index of last granted requester
credit_overflow  out  1  sticky: credit returned while count == MAX_CREDITS

Behaviour:
- Reset (rst low, asynchronous) forces:
  - state IN_RESET, credit_count 0, rr pointer 0, grant_id 0
  - push_valid 0, push_data 0, credit_overflow 0, push_sender_in_reset 1
- FSM states:
  - IN_RESET: one cycle after rst deasserts. push_sender_in_reset=1. Next state WAIT_RX if push_receiver_in_reset=1, else ACTIVE.
  - WAIT_RX: push_sender_in_reset=0. credit_count held at 0; push_credit ignored. Go to ACTIVE when push_receiver_in_reset=0.
  - ACTIVE: normal operation. If push_receiver_in_reset rises, go to WAIT_RX next cycle:
    - credit_count cleared to 0
    - any beat granted in that cycle is still driven on push_valid
- Arbitration (combinational, ACTIVE only):
  - Grant only when credit_count>0 and some req_valid is set.
  - Grant the first valid requester searching from rr pointer upward, wrapping at NUM_REQ-1 -> 0.
  - req_ready is one-hot or zero. req_ready=0 in all states other than ACTIVE and whenever credit_count==0.
- On grant of requester k:
  - next cycle push_valid=1 and push_data=req_data[k] (latency 1)
  - rr pointer = (k+1) mod NUM_REQ; grant_id=k
  - without a grant: push_valid=0 next cycle, push_data holds its value
- Credit arithmetic, per cycle in ACTIVE (inc=push_credit, dec=grant):
  - inc&dec: count unchanged
  - inc only: +1, saturating at MAX_CREDITS; a credit arriving at MAX sets credit_overflow (sticky until reset)
  - dec only: -1 (never below 0, guaranteed by the grant condition)
- push_credit_stall = 1 when state!=ACTIVE or credit_count==MAX_CREDITS (combinational).
- A beat is never issued in the same cycle the credit it uses is returned from 0. Grant is based on the registered count only; a credit arriving at count 0 is usable the next cycle.
- Mid-operation rst assertion: all outputs return to reset values immediately (asynchronous); in-flight push_valid is dropped.

Decomposition:
- Package credit_link_pkg:
  - state enum {IN_RESET, WAIT_RX, ACTIVE}
  - CNT_W/index-width helper functions
  - default MAX_CREDITS constant shared with receiver-side blocks
- One sub-module: rr_arbiter (parameter NUM_REQ; inputs req, ptr, enable; outputs one-hot grant and encoded index). Purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset handshake: release rst with push_receiver_in_reset=1 for 5 cycles.
  -> push_sender_in_reset=1 for the first cycle, then 0; FSM in WAIT_RX; credits pulsed during WAIT_RX leave credit_count=0; ACTIVE one cycle after receiver reset drops.
- Credit gating: ACTIVE, credit_count=0, req_valid=4'b0001.
  -> req_ready=0. Pulse push_credit once -> next cycle req_ready=0001; following cycle push_valid=1 with req_data[0]; credit_count back to 0.
- Round-robin fairness: MAX_CREDITS credits preloaded, all four req_valid held high, one credit returned per cycle.
  -> grant_id sequence 0,1,2,3,0,...; credit_count stays constant under simultaneous inc/dec.
- Saturation: return 5 credits with no requests, MAX_CREDITS=4.
  -> credit_count=4; push_credit_stall=1 once count reaches 4; credit_overflow=1 after the 5th.
- Receiver reset mid-traffic: count=3, requests active, push_receiver_in_reset pulsed.
  -> count=0 next cycle, req_ready=0, state WAIT_RX; traffic resumes only after new credits arrive.
- Async reset mid-beat: assert rst while push_valid=1.
  -> push_valid, credit_count and credit_overflow go to 0 immediately without waiting for a clock edge.
